div_issue: RTL and testbench



---
 rtl/fpu_pkg.sv | 50 +++++
 rtl/div_issue_fifo.sv | 62 ++++++
 rtl/div_issue.sv | 163 ++++++++++++++++
 tb/tb_div_issue.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FP16 field layout, issue-FSM state encoding and special-operand classification for the FPU units.
package fpu_pkg;

  localparam int FP16_W = 16;
  localparam int EXP_W  = 5;
  localparam int MAN_W  = 10;

  localparam logic [FP16_W-1:0] QNAN16  = 16'h7E00;
  localparam logic [EXP_W-1:0]  EXP_MAX = 5'h1F;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD
  } issue_state_e;

  typedef struct packed {
    logic              hit;
    logic [FP16_W-1:0] res;
  } fp16_special_t;

  // Division special cases; the checks are ordered so the first matching rule wins.
  function automatic fp16_special_t fp16_special(input logic [FP16_W-1:0] a,
                                                 input logic [FP16_W-1:0] b);
    fp16_special_t r;
    logic          s;
    logic          a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    s      = a[FP16_W-1] ^ b[FP16_W-1];
    a_nan  = (a[FP16_W-2 -: EXP_W] == EXP_MAX) && (a[MAN_W-1:0] != '0);
    b_nan  = (b[FP16_W-2 -: EXP_W] == EXP_MAX) && (b[MAN_W-1:0] != '0);
    a_inf  = (a[FP16_W-2 -: EXP_W] == EXP_MAX) && (a[MAN_W-1:0] == '0);
    b_inf  = (b[FP16_W-2 -: EXP_W] == EXP_MAX) && (b[MAN_W-1:0] == '0);
    a_zero = (a[FP16_W-2:0] == '0);
    b_zero = (b[FP16_W-2:0] == '0);
    r.hit  = 1'b1;
    if (a_nan || b_nan)                             r.res = QNAN16;
    else if ((a_zero && b_zero) || (a_inf && b_inf)) r.res = QNAN16;
    else if (b_zero)                                r.res = {s, EXP_MAX, {MAN_W{1'b0}}};
    else if (a_zero)                                r.res = {s, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
    else if (a_inf)                                 r.res = {s, EXP_MAX, {MAN_W{1'b0}}};
    else if (b_inf)                                 r.res = {s, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
    else begin
      r.hit = 1'b0;
      r.res = '0;
    end
    return r;
  endfunction

endpackage

// File: rtl/div_issue_fifo.sv
// Synchronous FIFO holding queued operand pairs for the divider sequencer.
// Latency: a pushed entry is visible at the head on the cycle after the push edge.
// Backpressure: push is ignored when full, pop is ignored when empty; simultaneous push/pop keeps level.
module div_issue_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          do_push, do_pop;

  assign full    = (level_q == (AW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign pop_dat = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is data-only; occupancy tracking makes stale entries unreachable after reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end

endmodule

// File: rtl/div_issue.sv
// Request sequencer for the FP16 iterative divider: queues operands, launches one op at a time, returns quotients in order.
// Latency: push to div_start 2 cycles, div_done to rsp_valid 1 cycle; DIV_ISSUE_FASTPATH_EN resolves special cases with rsp_valid 2 cycles after push.
// Backpressure: req_ready drops when the FIFO is full or after a sticky watchdog fault; a stalled response parks the sequencer in S_HOLD.
module div_issue
  import fpu_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int WATCHDOG = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [15:0]                req_a,
  input  logic [15:0]                req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [15:0]                rsp_data,
  output logic                       rsp_err,
  output logic                       div_start,
  output logic [15:0]                div_a,
  output logic [15:0]                div_b,
  input  logic [15:0]                div_out,
  input  logic                       div_done,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       fault
);
  localparam int            CW       = $clog2(WATCHDOG);
  localparam logic [CW-1:0] CNT_LAST = CW'(WATCHDOG - 1);

  logic         fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [31:0]  head_dat;
  logic [15:0]  head_a, head_b;

  issue_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   div_a_q, div_a_d, div_b_q, div_b_d, rsp_data_q, rsp_data_d;
  logic          rsp_err_q, rsp_err_d, rsp_valid_q, rsp_valid_d;
  logic          div_start_q, div_start_d, fault_q, fault_d;
  logic          live_q;

  // live_q keeps req_ready low while reset is applied, without a path from rst_n.
  assign req_ready          = live_q && !fifo_full && !fault_q;
  assign fifo_push          = req_valid && req_ready;
  assign {head_a, head_b}   = head_dat;

  div_issue_fifo #(
    .DEPTH (DEPTH),
    .W     (32)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fifo_push),
    .push_dat ({req_a, req_b}),
    .pop      (fifo_pop),
    .pop_dat  (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (level)
  );

`ifdef DIV_ISSUE_FASTPATH_EN
  fp16_special_t head_spec;
  assign head_spec = fp16_special(head_a, head_b);
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_a_d     = div_a_q;
    div_b_d     = div_b_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    rsp_valid_d = rsp_valid_q;
    div_start_d = 1'b0;
    fault_d     = fault_q;
    fifo_pop    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
`ifdef DIV_ISSUE_FASTPATH_EN
          if (head_spec.hit) begin
            rsp_data_d  = head_spec.res;
            rsp_err_d   = 1'b0;
            rsp_valid_d = 1'b1;
            state_d     = S_HOLD;
          end else
`endif
          begin
            div_a_d     = head_a;
            div_b_d     = head_b;
            div_start_d = 1'b1;
            state_d     = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A completion on the expiry cycle takes priority over the timeout.
        if (div_done) begin
          rsp_data_d  = div_out;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = S_HOLD;
        end else if (cnt_q == CNT_LAST) begin
          rsp_data_d  = QNAN16;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          fault_d     = 1'b1;
          state_d     = S_HOLD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HOLD: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      div_a_q     <= '0;
      div_b_q     <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      div_start_q <= 1'b0;
      fault_q     <= 1'b0;
      live_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_a_q     <= div_a_d;
      div_b_q     <= div_b_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      rsp_valid_q <= rsp_valid_d;
      div_start_q <= div_start_d;
      fault_q     <= fault_d;
      live_q      <= 1'b1;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign div_start = div_start_q;
  assign div_a     = div_a_q;
  assign div_b     = div_b_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_div_issue.sv
// Directed bench for div_issue with a behavioural divider whose latency and hang behaviour the test controls.
module tb_div_issue;
  localparam int DEPTH    = 4;
  localparam int WATCHDOG = 64;
  localparam int NV       = 19;
`ifdef DIV_ISSUE_FASTPATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   req_valid, req_ready;
  logic [15:0]            req_a, req_b;
  logic                   rsp_valid, rsp_ready;
  logic [15:0]            rsp_data;
  logic                   rsp_err;
  logic                   div_start;
  logic [15:0]            div_a, div_b;
  logic [15:0]            div_out;
  logic                   div_done;
  logic [$clog2(DEPTH):0] level;
  logic                   fault;

  always #5 clk = ~clk;

  div_issue #(.DEPTH(DEPTH), .WATCHDOG(WATCHDOG)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .div_start (div_start),
    .div_a     (div_a),
    .div_b     (div_b),
    .div_out   (div_out),
    .div_done  (div_done),
    .level     (level),
    .fault     (fault)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    bit          special;
  } vec_t;

  vec_t vec [NV];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] lookup(input logic [15:0] a, input logic [15:0] b);
    for (int i = 0; i < NV; i++)
      if (vec[i].a == a && vec[i].b == b) return vec[i].q;
    return 16'hDEAD;
  endfunction

  // Divider model: done pulse div_lat cycles after the start cycle, unless hung.
  int          div_lat  = 4;
  bit          div_hang = 1'b0;
  int          inj_cnt  = 0;
  int          inj_seen = 0;
  int          cnt_m    = 0;
  logic [15:0] out_m    = '0;

  initial begin
    div_done = 1'b0;
    div_out  = '0;
    forever begin
      @(posedge clk);
      #1;
      div_done = 1'b0;
      if (!rst_n) begin
        cnt_m = 0;
      end else begin
        if (inj_cnt != inj_seen) begin
          inj_seen = inj_cnt;
          div_done = 1'b1;
          div_out  = 16'h1234;
        end
        if (cnt_m > 0) begin
          cnt_m--;
          if (cnt_m == 0) begin
            div_done = 1'b1;
            div_out  = out_m;
          end
        end
        if (div_start) begin
          out_m = lookup(div_a, div_b);
          cnt_m = div_hang ? 0 : div_lat;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "simulation time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int i);
    int n, starts, exp_cyc;
    bit exp_fast;
    exp_fast  = FAST && vec[i].special;
    rsp_ready = 1'b1;
    req_a     = vec[i].a;
    req_b     = vec[i].b;
    req_valid = 1'b1;
    check($sformatf("v%0d_req_ready", i), req_ready, 1);
    tick();
    req_valid = 1'b0;
    n = 1;
    starts = 0;
    while (!rsp_valid && n < 200) begin
      if (div_start) begin
        starts++;
        check($sformatf("v%0d_div_a", i), div_a, vec[i].a);
        check($sformatf("v%0d_div_b", i), div_b, vec[i].b);
      end
      tick();
      n++;
    end
    exp_cyc = exp_fast ? 2 : 3 + div_lat;
    check($sformatf("v%0d_latency", i), n, exp_cyc);
    check($sformatf("v%0d_starts", i), starts, exp_fast ? 0 : 1);
    check($sformatf("v%0d_rsp_data", i), rsp_data, vec[i].q);
    check($sformatf("v%0d_rsp_err", i), rsp_err, 0);
    tick();
    check($sformatf("v%0d_rsp_consumed", i), rsp_valid, 0);
  endtask

  initial begin
    int n, n0, stable, starts, extra;
    vec[0]  = '{16'h3C00, 16'h4000, 16'h3800, 1'b0};
    vec[1]  = '{16'h4000, 16'h3C00, 16'h4000, 1'b0};
    vec[2]  = '{16'h4200, 16'h4000, 16'h3E00, 1'b0};
    vec[3]  = '{16'hC000, 16'h4000, 16'hBC00, 1'b0};
    vec[4]  = '{16'h4400, 16'h4000, 16'h4000, 1'b0};
    vec[5]  = '{16'h4000, 16'h0000, 16'h7C00, 1'b1};
    vec[6]  = '{16'hC000, 16'h0000, 16'hFC00, 1'b1};
    vec[7]  = '{16'h0000, 16'h4000, 16'h0000, 1'b1};
    vec[8]  = '{16'h8000, 16'h4000, 16'h8000, 1'b1};
    vec[9]  = '{16'h7C00, 16'h4000, 16'h7C00, 1'b1};
    vec[10] = '{16'h4000, 16'h7C00, 16'h0000, 1'b1};
    vec[11] = '{16'hC000, 16'h7C00, 16'h8000, 1'b1};
    vec[12] = '{16'h0000, 16'h0000, 16'h7E00, 1'b1};
    vec[13] = '{16'h7C00, 16'h7C00, 16'h7E00, 1'b1};
    vec[14] = '{16'h7E01, 16'h3C00, 16'h7E00, 1'b1};
    vec[15] = '{16'h3C00, 16'hFE00, 16'h7E00, 1'b1};
    vec[16] = '{16'h7C00, 16'h0000, 16'h7C00, 1'b1};
    vec[17] = '{16'hFC00, 16'h3C00, 16'hFC00, 1'b1};
    vec[18] = '{16'h3C00, 16'h8000, 16'hFC00, 1'b1};

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    repeat (3) tick();
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_div_start", div_start, 0);
    check("rst_fault", fault, 0);
    check("rst_rsp_data", rsp_data, 16'h0000);
    check("rst_div_a", div_a, 16'h0000);
    check("rst_div_b", div_b, 16'h0000);
    check("rst_level", level, 0);
    check("rst_req_ready", req_ready, 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_req_ready", req_ready, 1);

    for (int i = 0; i < NV; i++) run_vec(i);

    // Backpressure: DEPTH+1 pushes with the response port stalled.
    rsp_ready = 1'b0;
    for (int k = 0; k < DEPTH + 1; k++) begin
      req_a     = vec[k].a;
      req_b     = vec[k].b;
      req_valid = 1'b1;
      check($sformatf("bp_accept%0d", k), req_ready, 1);
      tick();
    end
    check("bp_level_full", level, DEPTH);
    check("bp_req_ready_low", req_ready, 0);
    req_a = vec[5].a;
    req_b = vec[5].b;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 50) begin
      tick();
      n++;
    end
    check("bp_first_rsp_seen", rsp_valid, 1);
    stable = 0;
    starts = 0;
    for (int j = 0; j < 10; j++) begin
      if (rsp_valid && rsp_data == vec[0].q && !rsp_err) stable++;
      if (div_start) starts++;
      tick();
    end
    check("hold_stable_cycles", stable, 10);
    check("hold_no_div_start", starts, 0);
    rsp_ready = 1'b1;
    for (int k = 0; k < DEPTH + 1; k++) begin
      n = 0;
      while (!rsp_valid && n < 50) begin
        tick();
        n++;
      end
      check($sformatf("bp_order%0d", k), rsp_data, vec[k].q);
      tick();
    end
    extra = 0;
    for (int j = 0; j < 15; j++) begin
      if (rsp_valid) extra++;
      tick();
    end
    check("bp_no_extra_rsp", extra, 0);
    check("bp_level_drained", level, 0);

    // Done on the same cycle the watchdog expires.
    div_lat = WATCHDOG;
    run_vec(0);
    check("tie_no_fault", fault, 0);
    div_lat = 4;

    // Watchdog timeout with a hung divider.
    div_hang  = 1'b1;
    req_a     = vec[0].a;
    req_b     = vec[0].b;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    n = 1;
    while (!div_start && n < 20) begin
      tick();
      n++;
    end
    check("to_div_start", div_start, 1);
    n0 = n;
    while (!rsp_valid && n < 200) begin
      tick();
      n++;
    end
    check("to_cycles", n - n0, WATCHDOG + 1);
    check("to_rsp_data", rsp_data, 16'h7E00);
    check("to_rsp_err", rsp_err, 1);
    check("to_fault", fault, 1);
    tick();
    check("to_req_ready_low", req_ready, 0);
    repeat (5) tick();
    check("to_fault_sticky", fault, 1);
    check("to_req_ready_sticky", req_ready, 0);

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("clr_fault", fault, 0);
    check("clr_req_ready", req_ready, 1);

    // Reset while an op is in flight with two entries queued.
    for (int k = 0; k < 3; k++) begin
      req_a     = vec[k].a;
      req_b     = vec[k].b;
      req_valid = 1'b1;
      tick();
    end
    req_valid = 1'b0;
    repeat (4) tick();
    check("mid_level_queued", level, 2);
    rst_n = 1'b0;
    tick();
    check("mid_rst_level", level, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_div_start", div_start, 0);
    rst_n = 1'b1;
    tick();
    inj_cnt++;
    extra  = 0;
    starts = 0;
    for (int j = 0; j < 8; j++) begin
      if (rsp_valid) extra++;
      if (div_start) starts++;
      tick();
    end
    check("late_done_no_rsp", extra, 0);
    check("late_done_no_start", starts, 0);
    check("late_done_level", level, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
